// File: rtl/fp16_to_int8_pkg.sv
// fp16_to_int8_pkg: shared FP16/INT8 constants and types for the FP16 -> INT8 quantiser.
package fp16_to_int8_pkg;
    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int FP16_EXP_BIAS = 15;
    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;
    localparam int EXP_OVF = 23;
    localparam int ROUND_RNE = 0;
    localparam int ROUND_TRUNC = 1;
    localparam int ALIGN_LSB = FP16_EXP_BIAS + MAN_W;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } fp16_t;

    typedef struct packed {
        logic       sign;
        logic       nan;
        logic       inf;
        logic       zero;
        logic       ovf;
        logic [7:0] mag;
        logic       guard;
        logic       sticky;
    } s1_t;

    localparam int S1_W = $bits(s1_t);
endpackage

// File: rtl/fp16_to_int8_round.sv
// fp16_to_int8_round: combinational round and saturate of a decoded FP16 magnitude to INT8.
module fp16_to_int8_round
    import fp16_to_int8_pkg::*;
#(
    parameter int ROUND_MODE = ROUND_RNE
) (
    input  logic [S1_W-1:0] s1_bits,
    output logic [7:0]      res,
    output logic            sat,
    output logic            nan
);
    s1_t        s;
    logic       inc;
    logic [8:0] rnd;
    logic       mag_ovf;

    always_comb begin
        s = s1_t'(s1_bits);
        inc = (ROUND_MODE == ROUND_RNE) && s.guard && (s.sticky || s.mag[0]);
        rnd = {1'b0, s.mag} + 9'(inc);
        // negative side reaches one further than positive
        mag_ovf = s.sign ? rnd > 9'(-INT8_MIN) : rnd > 9'(INT8_MAX);
        nan = s.nan;
        sat = !s.nan && !s.zero && (s.inf || s.ovf || mag_ovf);
        res = (s.nan || s.zero) ? 8'h00 :
              sat ? (s.sign ? 8'(INT8_MIN) : 8'(INT8_MAX)) :
              s.sign ? 8'(-rnd) : rnd[7:0];
    end
endmodule

// File: rtl/fp16_to_int8_stream.sv
// fp16_to_int8_stream: 2-stage FP16 -> INT8 quantiser with valid/ready backpressure.
// Defining FP16TOINT8_SAT_CNT_EN adds sat_clr/sat_cnt, a saturating count of clamped outputs.
module fp16_to_int8_stream
    import fp16_to_int8_pkg::*;
#(
    parameter int ROUND_MODE = ROUND_RNE
`ifdef FP16TOINT8_SAT_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sat,
    output logic        out_nan
`ifdef FP16TOINT8_SAT_CNT_EN
    ,
    input  logic             sat_clr,
    output logic [CNT_W-1:0] sat_cnt
`endif
);
    fp16_t       f;
    logic [32:0] aligned;
    s1_t         dec, s1_d, s1_q;
    logic        s1_valid_d, s1_valid_q, s1_adv;
    logic        out_valid_d, out_valid_q;
    logic [7:0]  out_data_d, out_data_q, rnd_data;
    logic        out_sat_d, out_sat_q, rnd_sat;
    logic        out_nan_d, out_nan_q, rnd_nan;

    always_comb begin
        f = fp16_t'(in_data);
        // value * 2^ALIGN_LSB as an integer: bits above ALIGN_LSB are the integer part
        aligned = {22'b0, 1'b1, f.man} << f.exp;
        dec.sign = f.sign;
        dec.nan = (&f.exp) && (|f.man);
        dec.inf = (&f.exp) && !(|f.man);
        dec.zero = !(|f.exp);
        dec.ovf = f.exp >= 5'(EXP_OVF);
        dec.mag = aligned[ALIGN_LSB +: 8];
        dec.guard = aligned[ALIGN_LSB-1];
        dec.sticky = |aligned[ALIGN_LSB-2:0];
        s1_adv = !out_valid_q || out_ready;
        in_ready = !s1_valid_q || s1_adv;
        s1_valid_d = in_ready ? in_valid : s1_valid_q;
        s1_d = (in_valid && in_ready) ? dec : s1_q;
        out_valid_d = s1_adv ? s1_valid_q : out_valid_q;
        out_data_d = (s1_valid_q && s1_adv) ? rnd_data : out_data_q;
        out_sat_d = (s1_valid_q && s1_adv) ? rnd_sat : out_sat_q;
        out_nan_d = (s1_valid_q && s1_adv) ? rnd_nan : out_nan_q;
    end

    fp16_to_int8_round #(.ROUND_MODE(ROUND_MODE)) u_round (
        .s1_bits(s1_q),
        .res    (rnd_data),
        .sat    (rnd_sat),
        .nan    (rnd_nan)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= 8'h00;
            out_sat_q <= 1'b0;
            out_nan_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q <= s1_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_sat_q <= out_sat_d;
            out_nan_q <= out_nan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_sat = out_sat_q;
    assign out_nan = out_nan_q;

`ifdef FP16TOINT8_SAT_CNT_EN
    logic [CNT_W-1:0] sat_cnt_d, sat_cnt_q;

    always_comb
        sat_cnt_d = sat_clr ? '0 :
                    (out_valid_q && out_ready && out_sat_q && !(&sat_cnt_q)) ? sat_cnt_q + CNT_W'(1) :
                    sat_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) sat_cnt_q <= '0;
        else sat_cnt_q <= sat_cnt_d;
    end

    assign sat_cnt = sat_cnt_q;
`endif
endmodule
